bounce_box_src: RTL

BOUNCE_BOX_SRC -- requirements
Module: bounce_box_src

---
 rtl/video_pkg.sv | 29 ++
 rtl/bounce_axis.sv | 66 ++++++
 rtl/bounce_box_src.sv | 110 +++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: coordinate widths, 3-bit colour codes and the
// mapping from a colour code to per-channel full-scale enables.
package video_pkg;

  localparam int COORD_W = 11;
  localparam int WIDE_W  = 12;

  typedef logic [COORD_W-1:0] coord_t;

  // A colour code is {red, grn, blu}; each set bit is a full-scale channel.
  localparam logic [2:0] COLOR_RED   = 3'b100;
  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  typedef struct packed {
    logic red;
    logic grn;
    logic blu;
  } rgb_en_t;

  function automatic rgb_en_t c_to_rgb(input logic [2:0] c);
    rgb_en_t en;
    en.red = c[2];
    en.grn = c[1];
    en.blu = c[0];
    return en;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position, direction and a flip flag that is
// raised combinationally in the cycle a motion step reverses direction.
module bounce_axis
  import video_pkg::*;
#(
  parameter int BOX_SIZE = 32
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   step_i,
  input  coord_t extent_i,
  output coord_t pos_o,
  output coord_t pos_d_o,
  output logic   dir_neg_o,
  output logic   flip_o
);

  localparam logic signed [WIDE_W-1:0] BOX_S = WIDE_W'(BOX_SIZE);

  coord_t                    pos_q, pos_d;
  logic                      dir_neg_q, dir_neg_d;
  logic signed [WIDE_W-1:0]  pos_s, dx_s, nx_s, ext_s;
  logic                      out_of_range;

  // Signed 12-bit math so a step below zero or past the far edge is visible.
  always_comb begin
    pos_s        = signed'({1'b0, pos_q});
    ext_s        = signed'({1'b0, extent_i});
    dx_s         = dir_neg_q ? -12'sd1 : 12'sd1;
    nx_s         = pos_s + dx_s;
    out_of_range = (nx_s < 0) || ((nx_s + BOX_S) > ext_s);
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pos_d     = pos_q;
    dir_neg_d = dir_neg_q;
    flip_o    = 1'b0;
    if (step_i) begin
      if (out_of_range) begin
        flip_o    = 1'b1;
        dir_neg_d = ~dir_neg_q;
        // Bounce back: bx - old dx.
        pos_d     = dir_neg_q ? pos_q + 1'b1 : pos_q - 1'b1;
      end else begin
        pos_d = nx_s[COORD_W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pos_q     <= '0;
      dir_neg_q <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      dir_neg_q <= dir_neg_d;
    end
  end

  assign pos_o     = pos_q;
  assign pos_d_o   = pos_d;
  assign dir_neg_o = dir_neg_q;

endmodule

// File: rtl/bounce_box_src.sv
// Test-pattern source: red border with a colour-cycling box that bounces one
// step per frame. o_pixel is registered from next-state values (zero lag).
module bounce_box_src
  import video_pkg::*;
#(
  parameter int BITS_PER_COLOR = 8,
  parameter int BOX_SIZE       = 32
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset,
  input  logic [COORD_W-1:0]          i_width,
  input  logic [COORD_W-1:0]          i_height,
  input  logic                        i_rd,
  input  logic                        i_newline,
  input  logic                        i_newframe,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel
);

  localparam int                 PIX_W = 3 * BITS_PER_COLOR;
  localparam logic [WIDE_W-1:0]  BOX_W = WIDE_W'(BOX_SIZE);

  coord_t             x_q, x_d, y_q, y_d;
  coord_t             bx_q, bx_d, by_q, by_d;
  logic [2:0]         c_q, c_d;
  logic               dx_neg, dy_neg, flip_x, flip_y;
  logic [2:0]         code_d;
  rgb_en_t            en_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;

  bounce_axis #(.BOX_SIZE(BOX_SIZE)) u_axis_x (
    .clk_i     (i_pixclk),
    .reset_i   (i_reset),
    .step_i    (i_newframe),
    .extent_i  (i_width),
    .pos_o     (bx_q),
    .pos_d_o   (bx_d),
    .dir_neg_o (dx_neg),
    .flip_o    (flip_x)
  );

  bounce_axis #(.BOX_SIZE(BOX_SIZE)) u_axis_y (
    .clk_i     (i_pixclk),
    .reset_i   (i_reset),
    .step_i    (i_newframe),
    .extent_i  (i_height),
    .pos_o     (by_q),
    .pos_d_o   (by_d),
    .dir_neg_o (dy_neg),
    .flip_o    (flip_y)
  );

  function automatic logic [2:0] colour_code(
    input coord_t x, input coord_t y, input coord_t bx, input coord_t by,
    input logic [2:0] c, input coord_t w, input coord_t h
  );
    logic in_box, on_border;
    in_box    = (x >= bx) && ({1'b0, x} < ({1'b0, bx} + BOX_W)) &&
                (y >= by) && ({1'b0, y} < ({1'b0, by} + BOX_W));
    on_border = (x == '0) || (x == w - 1'b1) || (y == '0) || (y == h - 1'b1);
    if (in_box)         return c;
    else if (on_border) return COLOR_RED;
    else                return COLOR_BLACK;
  endfunction

  // Position counters: newframe beats newline beats rd.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_newframe) begin
      x_d = '0;
      y_d = '0;
    end else if (i_newline) begin
      x_d = '0;
      if (y_q < i_height - 1'b1) y_d = y_q + 1'b1;
    end else if (i_rd) begin
      if (x_q < i_width - 1'b1) x_d = x_q + 1'b1;
    end
  end

  // A flip on either or both axes advances the colour exactly once.
  always_comb begin
    c_d = c_q;
    if (flip_x || flip_y) c_d = (c_q == 3'd7) ? 3'd1 : c_q + 3'd1;
  end

  always_comb begin
    code_d  = colour_code(x_d, y_d, bx_d, by_d, c_d, i_width, i_height);
    en_d    = c_to_rgb(code_d);
    pixel_d = {{BITS_PER_COLOR{en_d.red}},
               {BITS_PER_COLOR{en_d.grn}},
               {BITS_PER_COLOR{en_d.blu}}};
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= COLOR_WHITE;
      pixel_q <= '1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      pixel_q <= pixel_d;
    end
  end

  assign o_pixel = pixel_q;

endmodule
